ctrl_tx_serializer: RTL and testbench

Parametrised next-generation TX controller between the ALU/register file and the UART transmitter. It captures ALU results of ALU_BYTES bytes and register read bytes into independent one-entry holding slots. It serialises each captured result into WIDTH-bit bytes and sends them to the UART TX, one byte per Busy handshake. ALU frames have priority, and the register slot buffers a read that arrives during an ALU frame.

---
 rtl/ctrl_tx_serializer.sv | 145 ++++++++++++++
 tb/tb_ctrl_tx_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_tx_serializer.sv
`default_nettype none
// ============================================================================
// ctrl_tx_serializer : two-slot (ALU / register read) byte serializer to UART TX
// Revision 1.0
// ============================================================================
module ctrl_tx_serializer #(
  parameter int WIDTH     = 8,
  parameter int ALU_BYTES = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [ALU_BYTES*WIDTH-1:0] ALU_OUT,
  input  logic                       OUT_Valid,
  input  logic [WIDTH-1:0]           RdData,
  input  logic                       RdData_Valid,
  input  logic                       Busy,
  output logic [WIDTH-1:0]           TX_P_DATA,
  output logic                       TX_D_VLD,
  output logic                       ctrl_idle,
  output logic                       drop_pulse
);

  localparam int FW = ALU_BYTES * WIDTH;
  localparam int CW = $clog2(ALU_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t           state_q;
  logic [FW-1:0]    shift_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] tx_data_q;
  logic             tx_vld_q;

  logic             alu_full_q, alu_full_d;
  logic [FW-1:0]    alu_data_q;
  logic             reg_full_q, reg_full_d;
  logic [WIDTH-1:0] reg_data_q;
  logic             drop_q, drop_d;

  logic             alu_unload, reg_unload;
  logic             alu_cap, reg_cap;
  logic [WIDTH-1:0] cur_byte;
  logic [FW-1:0]    shift_next;
  logic [FW-1:0]    reg_load;

  // A slot being emptied by the FSM this cycle can accept a new strobe at once.
  assign alu_unload = (state_q == S_IDLE) && alu_full_q;
  assign reg_unload = (state_q == S_IDLE) && !alu_full_q && reg_full_q;
  assign alu_cap    = OUT_Valid    && (!alu_full_q || alu_unload);
  assign reg_cap    = RdData_Valid && (!reg_full_q || reg_unload);
  assign alu_full_d = alu_cap || (alu_full_q && !alu_unload);
  assign reg_full_d = reg_cap || (reg_full_q && !reg_unload);
  assign drop_d     = (OUT_Valid && !alu_cap) || (RdData_Valid && !reg_cap);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_byte   = shift_q[FW-1 -: WIDTH];
      assign shift_next = shift_q << WIDTH;
      assign reg_load   = FW'(reg_data_q) << (FW - WIDTH);
    end else begin : g_lsb_first
      assign cur_byte   = shift_q[WIDTH-1:0];
      assign shift_next = shift_q >> WIDTH;
      assign reg_load   = FW'(reg_data_q);
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_full_q <= 1'b0;
      alu_data_q <= '0;
      reg_full_q <= 1'b0;
      reg_data_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      alu_full_q <= alu_full_d;
      reg_full_q <= reg_full_d;
      drop_q     <= drop_d;
      if (alu_cap) begin
        alu_data_q <= ALU_OUT;
      end
      if (reg_cap) begin
        reg_data_q <= RdData;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (alu_full_q) begin
            shift_q <= alu_data_q;
            cnt_q   <= CW'(ALU_BYTES);
            state_q <= S_SEND;
          end else if (reg_full_q) begin
            shift_q <= reg_load;
            cnt_q   <= CW'(1);
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          // Busy still high here means the UART is finishing someone else's byte.
          if (!Busy) begin
            tx_data_q <= cur_byte;
            tx_vld_q  <= 1'b1;
            state_q   <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (Busy) begin
            tx_vld_q <= 1'b0;
            shift_q  <= shift_next;
            cnt_q    <= cnt_q - CW'(1);
            state_q  <= S_WAIT_LO;
          end
        end
        S_WAIT_LO: begin
          if (!Busy) begin
            state_q <= (cnt_q == '0) ? S_IDLE : S_SEND;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign drop_pulse = drop_q;
  assign ctrl_idle  = (state_q == S_IDLE) && !alu_full_q && !reg_full_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_tx_serializer.sv
`default_nettype none
// ============================================================================
// tb_ctrl_tx_serializer : self-checking bench, two DUT configurations + UART model
// Revision 1.0
// ============================================================================
module tb_ctrl_tx_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] alu_a = '0;
  logic [31:0] alu_b = '0;
  logic        ov_a = 1'b0, ov_b = 1'b0, rv_a = 1'b0, rv_b = 1'b0;
  logic [7:0]  rd_a = '0, rd_b = '0;
  logic [1:0]  busy_m = '0, busy_hold = '0, busy_w;
  logic [7:0]  txd0, txd1;
  logic [1:0]  vld_s, idle_s, drop_s;

  assign busy_w = busy_m | busy_hold;

  always #5 CLK = ~CLK;

  ctrl_tx_serializer #(.WIDTH(8), .ALU_BYTES(2), .MSB_FIRST(1'b0)) u_dut_a (
    .CLK(CLK), .RST(RST), .ALU_OUT(alu_a), .OUT_Valid(ov_a),
    .RdData(rd_a), .RdData_Valid(rv_a), .Busy(busy_w[0]),
    .TX_P_DATA(txd0), .TX_D_VLD(vld_s[0]), .ctrl_idle(idle_s[0]), .drop_pulse(drop_s[0])
  );

  ctrl_tx_serializer #(.WIDTH(8), .ALU_BYTES(4), .MSB_FIRST(1'b1)) u_dut_b (
    .CLK(CLK), .RST(RST), .ALU_OUT(alu_b), .OUT_Valid(ov_b),
    .RdData(rd_b), .RdData_Valid(rv_b), .Busy(busy_w[1]),
    .TX_P_DATA(txd1), .TX_D_VLD(vld_s[1]), .ctrl_idle(idle_s[1]), .drop_pulse(drop_s[1])
  );

  // UART receiver model: takes a byte when TX_D_VLD is seen, Busy rises 2 cycles later for 10 cycles.
  int         cyc = 0;
  int         dly[2] = '{0, 0};
  int         bc[2] = '{0, 0};
  int         edges[2] = '{0, 0};
  int         drops[2] = '{0, 0};
  logic       vprev[2] = '{1'b0, 1'b0};
  logic [7:0] rxq0[$], rxq1[$];
  int         rxc0[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (bc[c] > 0) begin
        bc[c]--;
        if (bc[c] == 0) busy_m[c] = 1'b0;
      end else if (dly[c] > 0) begin
        dly[c]--;
        if (dly[c] == 0) begin
          busy_m[c] = 1'b1;
          bc[c] = 10;
        end
      end else if (vld_s[c]) begin
        if (c == 0) begin
          rxq0.push_back(txd0);
          rxc0.push_back(cyc);
        end else begin
          rxq1.push_back(txd1);
        end
        dly[c] = 2;
      end
      if (vld_s[c] && !vprev[c]) edges[c]++;
      vprev[c] = vld_s[c];
      if (drop_s[c]) drops[c]++;
    end
  end

  int         tot = 0, bad = 0;
  int         base0 = 0, base1 = 0, s_cyc = 0;
  logic [7:0] expq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: an ALU result is its bytes in transmit order, a register read is one byte.
  task automatic push_alu16(input logic [15:0] a);
    for (int i = 0; i < 2; i++) expq.push_back(8'((a >> (8 * i)) & 16'hFF));
  endtask

  task automatic push_alu32_msb(input logic [31:0] b);
    for (int i = 0; i < 4; i++) expq.push_back(8'((b >> (8 * (3 - i))) & 32'hFF));
  endtask

  task automatic check_rx(input int ch, input string nm);
    int sz;
    sz = (ch == 0) ? rxq0.size() - base0 : rxq1.size() - base1;
    chk({nm, "_count"}, sz, expq.size());
    for (int i = 0; i < expq.size() && i < sz; i++)
      chk({nm, "_byte"}, (ch == 0) ? rxq0[base0 + i] : rxq1[base1 + i], expq[i]);
    expq.delete();
    base0 = rxq0.size();
    base1 = rxq1.size();
  endtask

  task automatic wait_idle(input int ch);
    int n;
    n = 0;
    repeat (3) @(negedge CLK);
    while (!(idle_s[ch] && !busy_m[ch] && !vld_s[ch]) && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_timeout", n < 3000, 1'b1);
  endtask

  // ALU strobe at t=0, optional reg strobe at t=off, optional 2nd ALU strobe at t=off2 (4..6).
  task automatic apply_a(input logic [15:0] a, input logic ur, input logic [7:0] r, input int off,
                         input logic u2, input logic [15:0] a2, input int off2);
    for (int t = 0; t <= 6; t++) begin
      @(negedge CLK);
      if (t == 0) begin
        alu_a = a;
        ov_a  = 1'b1;
        s_cyc = cyc;
      end else if (u2 && t == off2) begin
        alu_a = a2;
        ov_a  = 1'b1;
      end else begin
        ov_a = 1'b0;
      end
      rd_a = r;
      rv_a = ur && (t == off);
    end
    @(negedge CLK);
    ov_a = 1'b0;
    rv_a = 1'b0;
  endtask

  typedef struct {
    logic [15:0] alu;
    logic        use_rd;
    logic [7:0]  rd;
    int          rd_off;
    int          n;
    logic [7:0]  e0, e1, e2;
  } vec_t;

  vec_t vt[4];

  initial begin
    int d0, e0, n;
    logic [15:0] a, a2;
    logic [31:0] b;
    logic [7:0]  r;
    logic        ur, u2;
    int          off, off2;

    vt[0] = '{16'hA55A, 1'b0, 8'h00, 0, 2, 8'h5A, 8'hA5, 8'h00};
    vt[1] = '{16'hBEEF, 1'b1, 8'h3C, 1, 3, 8'hEF, 8'hBE, 8'h3C};
    vt[2] = '{16'h0000, 1'b1, 8'hFF, 0, 3, 8'h00, 8'h00, 8'hFF};
    vt[3] = '{16'hFFFF, 1'b1, 8'h81, 3, 3, 8'hFF, 8'hFF, 8'h81};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_vld", vld_s, 2'b00);
    chk("rst_data", {txd1, txd0}, 16'h0);
    chk("rst_drop", drop_s, 2'b00);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_idle", idle_s, 2'b11);

    // Table-driven frames on the 2-byte LSB-first instance
    for (int i = 0; i < 4; i++) begin
      d0 = drops[0];
      apply_a(vt[i].alu, vt[i].use_rd, vt[i].rd, vt[i].rd_off, 1'b0, 16'h0, 4);
      wait_idle(0);
      if (i == 0) chk("latency", rxc0[base0] - s_cyc, 3);
      expq.push_back(vt[i].e0);
      expq.push_back(vt[i].e1);
      if (vt[i].n > 2) expq.push_back(vt[i].e2);
      check_rx(0, "vec");
      chk("vec_drop", drops[0] - d0, 0);
      chk("vec_idle", idle_s[0], 1'b1);
    end

    // Strobes during an active frame: 0002 buffered, 0003 dropped while slot full
    d0 = drops[0];
    @(negedge CLK); alu_a = 16'h0001; ov_a = 1'b1;
    @(negedge CLK); ov_a = 1'b0;
    repeat (3) @(negedge CLK);
    alu_a = 16'h0002; ov_a = 1'b1;
    @(negedge CLK); ov_a = 1'b0;
    @(negedge CLK); alu_a = 16'h0003; ov_a = 1'b1;
    @(negedge CLK); ov_a = 1'b0;
    wait_idle(0);
    push_alu16(16'h0001);
    push_alu16(16'h0002);
    check_rx(0, "drop_seq");
    chk("drop_count", drops[0] - d0, 1);

    // Busy held high across the first SEND
    e0 = edges[0];
    busy_hold[0] = 1'b1;
    apply_a(16'h7E81, 1'b0, 8'h00, 0, 1'b0, 16'h0, 4);
    repeat (13) @(negedge CLK);
    chk("hold_edges", edges[0] - e0, 0);
    chk("hold_vld", vld_s[0], 1'b0);
    chk("hold_notidle", idle_s[0], 1'b0);
    busy_hold[0] = 1'b0;
    wait_idle(0);
    push_alu16(16'h7E81);
    check_rx(0, "hold");

    // Randomized frames against the reference model
    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom); a2 = 16'($urandom); r = 8'($urandom);
      ur = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
      off = $urandom_range(0, 3); off2 = $urandom_range(4, 6);
      d0 = drops[0];
      apply_a(a, ur, r, off, u2, a2, off2);
      wait_idle(0);
      push_alu16(a);
      if (u2) push_alu16(a2);
      if (ur) expq.push_back(r);
      check_rx(0, "rand");
      chk("rand_drop", drops[0] - d0, 0);
    end

    // 4-byte MSB-first instance
    e0 = edges[1];
    @(negedge CLK); alu_b = 32'h11223344; ov_b = 1'b1;
    @(negedge CLK); ov_b = 1'b0;
    wait_idle(1);
    push_alu32_msb(32'h11223344);
    check_rx(1, "msb");
    chk("msb_edges", edges[1] - e0, 4);
    for (int k = 0; k < 3; k++) begin
      b = $urandom;
      @(negedge CLK); alu_b = b; ov_b = 1'b1;
      @(negedge CLK); ov_b = 1'b0;
      wait_idle(1);
      push_alu32_msb(b);
      check_rx(1, "msb_rand");
    end

    // Reset asserted in WAIT_LO after byte 1 of 2
    apply_a(16'hC3A5, 1'b0, 8'h00, 0, 1'b0, 16'h0, 4);
    n = 0;
    while (!((rxq0.size() - base0) == 1 && busy_m[0] && !vld_s[0]) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("rstmid_timeout", n < 200, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    chk("rstmid_pre_data", txd0, 8'hA5);
    #2 RST = 1'b0;
    #1;
    chk("rstmid_data", txd0, 8'h00);
    chk("rstmid_vld", vld_s[0], 1'b0);
    chk("rstmid_idle", idle_s[0], 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    e0 = edges[0];
    @(negedge CLK);
    chk("rstmid_idle_rel", idle_s[0], 1'b1);
    repeat (40) @(negedge CLK);
    chk("rstmid_edges", edges[0] - e0, 0);
    expq.push_back(8'hA5);
    check_rx(0, "rstmid");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire
